// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register-file sequencer and any other
// block that drives the RF controls.
//   - FunSel codes, command opcodes, RF addresses, sequencer state encoding
//   - is_reserved_op(): true for the two unused opcodes
package rf_pkg;

  localparam int RF_DATA_W = 8;

  // RF function select
  localparam logic [1:0] FS_CLR  = 2'b00;
  localparam logic [1:0] FS_LOAD = 2'b01;
  localparam logic [1:0] FS_DEC  = 2'b10;
  localparam logic [1:0] FS_INC  = 2'b11;

  // Command opcodes
  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_MOV  = 3'b100;
  localparam logic [2:0] OP_SWAP = 3'b101;

  // RF addresses: 0xx -> T(xx+1), 1xx -> R(xx+1)
  localparam logic [2:0] ADDR_T1 = 3'b000;
  localparam logic [2:0] ADDR_T2 = 3'b001;
  localparam logic [2:0] ADDR_T3 = 3'b010;
  localparam logic [2:0] ADDR_T4 = 3'b011;
  localparam logic [2:0] ADDR_R1 = 3'b100;
  localparam logic [2:0] ADDR_R2 = 3'b101;
  localparam logic [2:0] ADDR_R3 = 3'b110;
  localparam logic [2:0] ADDR_R4 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_W1   = 2'b01,
    ST_W2   = 2'b10,
    ST_W3   = 2'b11
  } state_t;

  function automatic logic is_reserved_op(input logic [2:0] op);
    return op[2:1] == 2'b11;
  endfunction

endpackage

// File: rtl/rf_sel_decode.sv
// rf_sel_decode: turns an RF address plus a write enable into the one-hot
// R/T enable vectors the register file expects.
//   addr  in  3  RF address (0xx = T(xx+1), 1xx = R(xx+1))
//   en    in  1  write enable; both outputs are zero when low
//   r_sel out 4  R enables, bit3 = R1 .. bit0 = R4
//   t_sel out 4  T enables, bit3 = T1 .. bit0 = T4
module rf_sel_decode
  import rf_pkg::*;
(
  input  logic [2:0] addr,
  input  logic       en,
  output logic [3:0] r_sel,
  output logic [3:0] t_sel
);

  logic [3:0] one_hot;

  always_comb begin
    r_sel   = 4'b0000;
    t_sel   = 4'b0000;
    // Register 1 of a bank sits in the MSB, so shift right by the index.
    one_hot = 4'b1000 >> addr[1:0];
    if (en) begin
      if (addr[2]) r_sel = one_hot;
      else         t_sel = one_hot;
    end
  end

endmodule

// File: rtl/rf_sequencer.sv
// rf_sequencer: accepts one register-transfer command per valid/ready
// handshake and expands it into RF write cycles (one for CLR/LDI/INC/DEC/MOV,
// three for SWAP through the scratch register).
//   clk, reset              clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_op/dst/src/imm      command fields, latched on acceptance
//   done, err               registered completion / illegal-command pulses
//   rf_O1Sel..rf_i          RF control outputs (combinational from state)
//   rf_O1                   RF read port 1 data, looped back for MOV/SWAP
//   dbg_state               current FSM state, for observation only
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE while reset is low;
// the command fields are captured on that edge and later input changes have
// no effect on the command in flight.
module rf_sequencer
  import rf_pkg::*;
#(
  parameter int         DATA_W   = 8,
  parameter logic [2:0] SWAP_TMP = ADDR_T4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [2:0]        cmd_dst,
  input  logic [2:0]        cmd_src,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              done,
  output logic              err,
  output logic [2:0]        rf_O1Sel,
  output logic [2:0]        rf_O2Sel,
  output logic [1:0]        rf_FunSel,
  output logic [3:0]        rf_RSel,
  output logic [3:0]        rf_TSel,
  output logic [DATA_W-1:0] rf_i,
  input  logic [DATA_W-1:0] rf_O1,
  output state_t            dbg_state
);

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [2:0]        dst_q, dst_d;
  logic [2:0]        src_q, src_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic              illegal;
  logic              wr_en;
  logic [2:0]        wr_addr;

  assign cmd_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign illegal   = is_reserved_op(cmd_op) ||
                     ((cmd_op == OP_SWAP) &&
                      ((cmd_dst == SWAP_TMP) || (cmd_src == SWAP_TMP)));

  // Next state, latched command and completion pulses
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    src_d   = src_q;
    imm_d   = imm_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = cmd_op;
          dst_d = cmd_dst;
          src_d = cmd_src;
          imm_d = cmd_imm;
          // Illegal commands never leave IDLE; they just report next cycle.
          if (illegal) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d = ST_W1;
          end
        end
      end
      ST_W1: begin
        if (op_q == OP_SWAP) begin
          state_d = ST_W2;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_W2: state_d = ST_W3;
      ST_W3: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RF controls; FunSel=load and O1Sel=0 are the resting values
  always_comb begin
    rf_O1Sel  = 3'b000;
    rf_FunSel = FS_LOAD;
    rf_i      = '0;
    wr_en     = 1'b0;
    wr_addr   = dst_q;
    unique case (state_q)
      ST_W1: begin
        wr_en = 1'b1;
        unique case (op_q)
          OP_CLR: rf_FunSel = FS_CLR;
          OP_LDI: rf_i      = imm_q;
          OP_INC: rf_FunSel = FS_INC;
          OP_DEC: rf_FunSel = FS_DEC;
          OP_MOV: begin
            rf_O1Sel = src_q;
            rf_i     = rf_O1;
          end
          OP_SWAP: begin
            rf_O1Sel = src_q;
            rf_i     = rf_O1;
            wr_addr  = SWAP_TMP;
          end
          default: wr_en = 1'b0;
        endcase
      end
      ST_W2: begin
        wr_en    = 1'b1;
        rf_O1Sel = dst_q;
        rf_i     = rf_O1;
        wr_addr  = src_q;
      end
      ST_W3: begin
        wr_en    = 1'b1;
        rf_O1Sel = SWAP_TMP;
        rf_i     = rf_O1;
        wr_addr  = dst_q;
      end
      default: ;
    endcase
  end

  // Reset gates the enables so an interrupted sequence writes nothing more.
  rf_sel_decode u_sel_decode (
    .addr  (wr_addr),
    .en    (wr_en && !reset),
    .r_sel (rf_RSel),
    .t_sel (rf_TSel)
  );

  assign rf_O2Sel  = dst_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= 3'b000;
      dst_q   <= 3'b000;
      src_q   <= 3'b000;
      imm_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      imm_q   <= imm_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_rf_sequencer.sv
module tb_rf_sequencer;
  import rf_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op, cmd_dst, cmd_src;
  logic [7:0] cmd_imm;
  logic       done, err;
  logic [2:0] rf_O1Sel, rf_O2Sel;
  logic [1:0] rf_FunSel;
  logic [3:0] rf_RSel, rf_TSel;
  logic [7:0] rf_i, rf_O1, rf_O2;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected write cycles: {cycle, O1Sel, FunSel, RSel, TSel, rf_i}
  logic [36:0] exp_q[$];
  // Expected completions: {cycle, err}
  logic [16:0] exp_done_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rf_sequencer #(.DATA_W(8), .SWAP_TMP(3'b011)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
    .done(done), .err(err), .rf_O1Sel(rf_O1Sel), .rf_O2Sel(rf_O2Sel),
    .rf_FunSel(rf_FunSel), .rf_RSel(rf_RSel), .rf_TSel(rf_TSel),
    .rf_i(rf_i), .rf_O1(rf_O1), .dbg_state(dbg_state)
  );

  // ---------------- register file model ----------------
  logic [7:0] regs [8];
  initial for (int i = 0; i < 8; i++) regs[i] = 8'h00;
  assign rf_O1 = regs[rf_O1Sel];
  assign rf_O2 = regs[rf_O2Sel];

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      logic [2:0] a;
      logic       en;
      a  = 3'(i);
      en = a[2] ? rf_RSel[3 - a[1:0]] : rf_TSel[3 - a[1:0]];
      if (en) begin
        case (rf_FunSel)
          2'b00: regs[i] <= 8'h00;
          2'b01: regs[i] <= rf_i;
          2'b10: regs[i] <= regs[i] - 8'h01;
          default: regs[i] <= regs[i] + 8'h01;
        endcase
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input int c, input logic [2:0] o1, input logic [1:0] fs,
                         input logic [3:0] rs, input logic [3:0] ts, input logic [7:0] d);
    exp_q.push_back({16'(c), o1, fs, rs, ts, d});
  endtask

  task automatic push_done(input int c, input logic e);
    exp_done_q.push_back({16'(c), e});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [36:0] got_w;
    logic [16:0] got_d;
    if ((rf_RSel != 4'b0000) || (rf_TSel != 4'b0000)) begin
      got_w = {16'(cyc), rf_O1Sel, rf_FunSel, rf_RSel, rf_TSel, rf_i};
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got %0h expected none (t=%0t)", got_w, $time);
      end else begin
        chk("write_cycle", got_w, exp_q.pop_front());
      end
    end
    if (done === 1'b1) begin
      got_d = {16'(cyc), err};
      if (exp_done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got %0h expected none (t=%0t)", got_d, $time);
      end else begin
        chk("done_pulse", got_d, exp_done_q.pop_front());
      end
    end else if (err === 1'b1) begin
      checks++; errors++;
      $display("FAIL err_without_done: got 1 expected 0 (t=%0t)", $time);
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                       input logic [7:0] imm, output int acc);
    int n = 0;
    acc = -1;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got 0 expected 1 (t=%0t)", $time);
      return;
    end
    cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    // Scramble inputs: the accepted command must not follow them.
    cmd_valid = 1'b0;
    cmd_op  = 3'($urandom_range(0, 7));
    cmd_dst = 3'($urandom_range(0, 7));
    cmd_src = 3'($urandom_range(0, 7));
    cmd_imm = 8'($urandom_range(0, 255));
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Single-write LDI with its expected write and completion
  task automatic ldi(input logic [2:0] dst, input logic [7:0] v,
                     input logic [3:0] rs, input logic [3:0] ts);
    int acc;
    issue(OP_LDI, dst, 3'b000, v, acc);
    push_wr(acc, 3'b000, FS_LOAD, rs, ts, v);
    push_done(acc + 1, 1'b0);
    settle();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int acc, acc2;
    logic [7:0] snap [8];

    reset = 1'b1; cmd_valid = 1'b0;
    cmd_op = 3'b000; cmd_dst = 3'b000; cmd_src = 3'b000; cmd_imm = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", cmd_ready, 1'b0);
    chk("reset_done", {done, err}, 2'b00);
    chk("reset_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    #1;
    chk("idle_ready", cmd_ready, 1'b1);
    chk("idle_outputs", {rf_O1Sel, rf_FunSel, rf_RSel, rf_TSel, rf_i},
        {3'b000, 2'b01, 4'b0000, 4'b0000, 8'h00});

    // LDI R2 <- 5A
    issue(OP_LDI, ADDR_R2, 3'b000, 8'h5A, acc);
    push_wr(acc, 3'b000, 2'b01, 4'b0100, 4'b0000, 8'h5A);
    push_done(acc + 1, 1'b0);
    chk("ldi_busy_ready", cmd_ready, 1'b0);
    settle();
    chk("ldi_r2_o2", {rf_O2Sel, rf_O2}, {3'b101, 8'h5A});

    // LDI T3 <- FF, INC wraps to 00, DEC back to FF
    ldi(ADDR_T3, 8'hFF, 4'b0000, 4'b0010);
    issue(OP_INC, ADDR_T3, 3'b000, 8'h00, acc);
    push_wr(acc, 3'b000, 2'b11, 4'b0000, 4'b0010, 8'h00);
    push_done(acc + 1, 1'b0);
    settle();
    chk("inc_wrap_t3", regs[3'b010], 8'h00);
    issue(OP_DEC, ADDR_T3, 3'b000, 8'h00, acc);
    push_wr(acc, 3'b000, 2'b10, 4'b0000, 4'b0010, 8'h00);
    push_done(acc + 1, 1'b0);
    settle();
    chk("dec_wrap_t3", regs[3'b010], 8'hFF);

    // SWAP R1(11) <-> R4(44): T4 <- R4, R4 <- R1, R1 <- T4
    ldi(ADDR_R1, 8'h11, 4'b1000, 4'b0000);
    ldi(ADDR_R4, 8'h44, 4'b0001, 4'b0000);
    issue(OP_SWAP, ADDR_R1, ADDR_R4, 8'h00, acc);
    push_wr(acc,     3'b111, 2'b01, 4'b0000, 4'b0001, 8'h44);
    push_wr(acc + 1, 3'b100, 2'b01, 4'b0001, 4'b0000, 8'h11);
    push_wr(acc + 2, 3'b011, 2'b01, 4'b1000, 4'b0000, 8'h44);
    push_done(acc + 3, 1'b0);
    settle();
    chk("swap_r1_r4", {regs[3'b100], regs[3'b111]}, {8'h44, 8'h11});

    // Illegal: SWAP touching T4, and a reserved opcode
    for (int i = 0; i < 8; i++) snap[i] = regs[i];
    issue(OP_SWAP, ADDR_T4, ADDR_R1, 8'h00, acc);
    push_done(acc, 1'b1);
    settle();
    issue(3'b110, ADDR_R1, ADDR_R2, 8'h77, acc);
    push_done(acc, 1'b1);
    settle();
    issue(OP_SWAP, ADDR_R2, ADDR_T4, 8'h00, acc);
    push_done(acc, 1'b1);
    settle();
    for (int i = 0; i < 8; i++) chk($sformatf("illegal_unchanged_%0d", i), regs[i], snap[i]);

    // MOV R3 <- T1(A5), then a command accepted in the done cycle
    ldi(ADDR_T1, 8'hA5, 4'b0000, 4'b1000);
    issue(OP_MOV, ADDR_R3, ADDR_T1, 8'h00, acc);
    push_wr(acc, 3'b000, 2'b01, 4'b0010, 4'b0000, 8'hA5);
    push_done(acc + 1, 1'b0);
    issue(OP_LDI, ADDR_R2, 3'b000, 8'h33, acc2);
    push_wr(acc2, 3'b000, 2'b01, 4'b0100, 4'b0000, 8'h33);
    push_done(acc2 + 1, 1'b0);
    chk("back_to_back_accept", acc2, acc + 2);
    settle();
    chk("mov_r3", regs[3'b110], 8'hA5);
    chk("ldi_r2_after", regs[3'b101], 8'h33);

    // Reset during W2 of SWAP dst=R4 src=R1 (R1=11, R4=44)
    ldi(ADDR_R1, 8'h11, 4'b1000, 4'b0000);
    ldi(ADDR_R4, 8'h44, 4'b0001, 4'b0000);
    issue(OP_SWAP, ADDR_R4, ADDR_R1, 8'h00, acc);
    push_wr(acc, 3'b100, 2'b01, 4'b0000, 4'b0001, 8'h11);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("reset_w2_enables", {rf_RSel, rf_TSel}, 8'h00);
    chk("reset_w2_ready", cmd_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("reset_w2_state", dbg_state, ST_IDLE);
    chk("reset_w2_done", {done, err}, 2'b00);
    settle();
    chk("reset_w2_regs", {regs[3'b011], regs[3'b111], regs[3'b100]}, {8'h11, 8'h44, 8'h11});

    chk("writes_drained", exp_q.size(), 0);
    chk("dones_drained", exp_done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #50000;
    errors++;
    $display("FAIL global_timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rf_sequencer.md
# rf_sequencer

Command-driven sequencer for the 8-register file (R1–R4, T1–T4) that owns all RF control inputs: operand selects, function select, R/T enables and the write-data input. It accepts one register-transfer command per valid/ready handshake and expands it into one or three RF write cycles. MOV and SWAP move data through the RF's O1 read port, and SWAP uses T4 as scratch. It sits between the control unit and the RF, so no other block drives the RF controls.

## Interface
- DATA_W, 8, RF word width
- SWAP_TMP, 3'b011, RF address of the SWAP scratch register (T4)
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  000 CLR, 001 LDI, 010 INC, 011 DEC, 100 MOV, 101 SWAP, 110/111 reserved
- cmd_dst  in  3  destination RF address
- cmd_src  in  3  source RF address (MOV, SWAP)
- cmd_imm  in  DATA_W  immediate value (LDI)
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, for illegal commands
- rf_O1Sel  out  3  RF read port 1 select
- rf_O2Sel  out  3  RF read port 2 select, always the latched dst
- rf_FunSel  out  2  00 clear, 01 load, 10 decrement, 11 increment
- rf_RSel  out  4  R enables, bit3 = R1 … bit0 = R4
- rf_TSel  out  4  T enables, bit3 = T1 … bit0 = T4
- rf_i  out  DATA_W  RF write data
- rf_O1  in  DATA_W  RF read port 1 data

RF address encoding:
- 0xx selects T(xx+1).
- 1xx selects R(xx+1).

## Operation
- States: IDLE, W1, W2, W3.
- cmd_ready = 1 only in IDLE with reset low.
- Handshake: a command is accepted on an edge where cmd_valid && cmd_ready are both high. op, dst, src and imm are latched on that edge.
- Legal single-write ops go IDLE→W1→IDLE.
- SWAP goes IDLE→W1→W2→W3→IDLE.
- Illegal commands stay in IDLE and produce done=err=1 in the next cycle, with no RF write. A command is illegal if:
  - op is reserved, or
  - op is SWAP and either dst or src equals SWAP_TMP.
- W1 actions by op:
  - CLR: enable dst, FunSel=00.
  - LDI: enable dst, FunSel=01, rf_i=imm.
  - INC: enable dst, FunSel=11.
  - DEC: enable dst, FunSel=10.
  - MOV: O1Sel=src, rf_i=rf_O1, FunSel=01, enable dst.
- SWAP cycles, all with FunSel=01 and rf_i=rf_O1:
  - W1: O1Sel=src, enable SWAP_TMP.
  - W2: O1Sel=dst, enable src.
  - W3: O1Sel=SWAP_TMP, enable dst.
- Exactly one enable bit is high in any W state; all enables are 0 in IDLE.
- MOV and SWAP with src==dst are legal. The register value is unchanged, and the cycle count is as normal.
- INC/DEC wrap modulo 2^DATA_W (the register behaviour); the sequencer does not detect wrap.
- Idle output values: O1Sel=000, FunSel=01, rf_i=0.

## Timing
- Command accepted at edge k:
  - Single-write op: W1 is cycle k+1 and the RF commits at the end of k+1. done is high in cycle k+2, when the sequencer is back in IDLE with cmd_ready=1.
  - SWAP: writes commit at the ends of k+1, k+2 and k+3; done is high in k+4.
  - Illegal command: done=err=1 in k+1.
- A new command may be accepted in the same cycle done is high. Maximum throughput is one single-write op every 2 cycles.
- done and err are registered.
- RF control outputs are combinational from the state and latched command.
- Reset:
  - Any edge with reset high forces IDLE and clears done, err and the latched command.
  - All enables are gated with !reset, so no RF write occurs in a cycle where reset is high. A SWAP interrupted mid-sequence is abandoned, and partial writes stand.
  - cmd_ready=0 while reset is high.
- Once accepted, a command is not affected by cmd_valid or the command inputs changing.

## Structure
- Shared package rf_pkg holds:
  - FunSel constants FS_CLR/FS_LOAD/FS_DEC/FS_INC.
  - Op constants OP_CLR … OP_SWAP.
  - Address constants ADDR_T1 … ADDR_R4.
  - State encoding.
- Sub-module rf_sel_decode: 3-bit address plus an enable bit → {RSel, TSel} one-hot. It is combinational and reused by the control unit.

## Test plan
- Reset, then LDI R2 ← 8'h5A → cmd_ready=0 in cycle k+1, RSel=0100, FunSel=01, rf_i=8'h5A; done=1 in k+2; O2 (R2) reads 8'h5A.
- LDI T3 ← 8'hFF, then INC T3 → final T3 = 8'h00, TSel=0010 in the write cycle. DEC then gives 8'hFF.
- R1=8'h11 and R4=8'h44, SWAP dst=R1 src=R4 → three write cycles with enables T4, R4, R1 in order. R1=8'h44, R4=8'h11; done in k+4.
- SWAP dst=T4 (or op=3'b110) → done=err=1 in k+1; no enable ever high; all registers unchanged.
- MOV R3←T1 with T1=8'hA5 → O1Sel=000 and rf_i=8'hA5 in W1; R3=8'hA5. A back-to-back command is accepted in the done cycle.
- Assert reset during W2 of a SWAP of R1 (8'h11) and R4 (8'h44) → no enable in the reset cycle. Afterwards: T4=8'h11, R4=8'h44 (W2 write blocked), R1=8'h11; state IDLE; done=0.
